key_write_ctrl: RTL

Command sequencer between the keypad scanner and the register bank that stores per-cell colour codes. It filters the scanner's raw key indication into clean single key events. It collects a two-key sequence (cell address, then colour) and issues a one-cycle write into the bank. It also drives the bank read address so the display and VGA stages show the cell being edited.

---
 rtl/key_write_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/key_write_ctrl.sv
// key_write_ctrl: takes the keypad scanner's raw level and turns it into
// debounced single key events. An address key followed by a colour key
// produces one write strobe into the colour register bank. The read cursor
// follows the cell being edited.
//
// Key filter FSM
//   state | meaning
//   REL   | no key held, waiting for key_valid
//   PCNT  | key seen, qualifying a stable press
//   HELD  | press accepted, waiting for release
//   RCNT  | release seen, qualifying a stable release
//
// Sequencer FSM
//   state    | meaning
//   IDLE     | waiting for an address key
//   SEL_DATA | address chosen, waiting for a colour key or timeout
//   WRITE    | one-cycle write strobe to the bank
module key_write_ctrl #(
    parameter int AW          = 4,
    parameter int DW          = 3,
    parameter int HOLD_CYC    = 500000,
    parameter int TIMEOUT_CYC = 150000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    key_code,
    input  logic          key_valid,
    output logic [AW-1:0] addrW,
    output logic [DW-1:0] datW,
    output logic          RegWrite,
    output logic [AW-1:0] addrR,
    output logic [1:0]    state_o,
    output logic          timeout
);

    localparam int HCW = $clog2(HOLD_CYC + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYC - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]     KEY_ESC   = 4'hF;

    typedef enum logic [1:0] {REL, PCNT, HELD, RCNT} flt_t;
    typedef enum logic [1:0] {IDLE = 2'd0, SEL_DATA = 2'd1, WRITE = 2'd2} seq_t;

    flt_t           flt_state, flt_next;
    logic [HCW-1:0] hcnt, hcnt_next;
    logic [3:0]     key_lat, key_lat_next;
    logic           key_ev;

    seq_t           seq_state, seq_next;
    logic [TCW-1:0] tcnt, tcnt_next;
    logic           ld_addr, ld_dat, to_fire;
    logic           colour_ok;

    // Key filter state, hold counter and latched key code
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flt_state <= REL;
            hcnt      <= '0;
            key_lat   <= '0;
        end else begin
            flt_state <= flt_next;
            hcnt      <= hcnt_next;
            key_lat   <= key_lat_next;
        end
    end

    // Key filter transitions; key_ev marks the cycle a press is accepted
    always_comb begin
        flt_next     = flt_state;
        hcnt_next    = hcnt;
        key_lat_next = key_lat;
        key_ev       = 1'b0;
        case (flt_state)
            REL: begin
                if (key_valid) begin
                    key_lat_next = key_code;
                    hcnt_next    = '0;
                    flt_next     = PCNT;
                end
            end
            PCNT: begin
                if (!key_valid || key_code != key_lat) begin
                    flt_next = REL;
                end else if (hcnt == HOLD_LAST) begin
                    key_ev   = 1'b1;
                    flt_next = HELD;
                end else begin
                    hcnt_next = hcnt + 1'b1;
                end
            end
            HELD: begin
                if (!key_valid) begin
                    hcnt_next = '0;
                    flt_next  = RCNT;
                end
            end
            RCNT: begin
                if (key_valid) begin
                    flt_next = HELD;
                end else if (hcnt == HOLD_LAST) begin
                    flt_next = REL;
                end else begin
                    hcnt_next = hcnt + 1'b1;
                end
            end
            default: flt_next = REL;
        endcase
    end

    // Only codes that fit in the data width are colours
    assign colour_ok = ((key_lat >> DW) == 4'd0);

    // Sequencer state and colour-select timeout counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_state <= IDLE;
            tcnt      <= '0;
        end else begin
            seq_state <= seq_next;
            tcnt      <= tcnt_next;
        end
    end

    // Sequencer transitions; timeout expiry takes priority over a key event
    always_comb begin
        seq_next  = seq_state;
        tcnt_next = tcnt;
        ld_addr   = 1'b0;
        ld_dat    = 1'b0;
        to_fire   = 1'b0;
        case (seq_state)
            IDLE: begin
                if (key_ev && key_lat != KEY_ESC) begin
                    ld_addr   = 1'b1;
                    tcnt_next = '0;
                    seq_next  = SEL_DATA;
                end
            end
            SEL_DATA: begin
                if (tcnt == TO_LAST) begin
                    to_fire  = 1'b1;
                    seq_next = IDLE;
                end else begin
                    tcnt_next = tcnt + 1'b1;
                    if (key_ev) begin
                        if (key_lat == KEY_ESC) begin
                            seq_next = IDLE;
                        end else if (colour_ok) begin
                            ld_dat   = 1'b1;
                            seq_next = WRITE;
                        end
                    end
                end
            end
            WRITE:   seq_next = IDLE;
            default: seq_next = IDLE;
        endcase
    end

    // Registered bank interface; addresses and data hold between updates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrW    <= '0;
            addrR    <= '0;
            datW     <= '0;
            RegWrite <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            RegWrite <= ld_dat;
            timeout  <= to_fire;
            if (ld_addr) begin
                addrW <= AW'(key_lat);
                addrR <= AW'(key_lat);
            end
            if (ld_dat) begin
                datW <= DW'(key_lat);
            end
        end
    end

    assign state_o = seq_state;

endmodule
